// File: rtl/neuron_mac_ctrl_pkg.sv
// Shared fixed-point / neuron-controller package (nn_fxp_pkg).
// Holds the default Q-format sizing, the controller FSM encodings and the
// saturation limits that the MAC controller and activation blocks share.
package nn_fxp_pkg;

    // Default Q-format and datapath sizing (Q8.8 operands, 40-bit accumulator).
    localparam int Q_DATA_W   = 16;
    localparam int Q_FRAC_W   = 8;
    localparam int Q_ACC_W    = 40;
    localparam int Q_ADDR_W   = 10;
    localparam int Q_MULT_LAT = 3;

    // Controller FSM encodings, kept as plain constants for legacy netlists.
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] CLEAR = 3'd1;
    localparam logic [2:0] ISSUE = 3'd2;
    localparam logic [2:0] DRAIN = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    // Saturation limits for the default result width.
    localparam logic [Q_DATA_W-1:0] SAT_MAX = 16'h7FFF;
    localparam logic [Q_DATA_W-1:0] SAT_MIN = 16'h8000;

endpackage

// File: rtl/neuron_mac_ctrl_if.sv
// Bus bundle between the layer scheduler / RAMs / DSP multiplier and the
// neuron MAC controller. The controller takes the slave view; the
// environment (scheduler, RAMs, multiplier) takes the master view.
interface neuron_mac_ctrl_if
    import nn_fxp_pkg::*;
#(
    parameter int DATA_W = Q_DATA_W,
    parameter int ADDR_W = Q_ADDR_W
);
    // Scheduler handshake
    logic                start;
    logic [ADDR_W-1:0]   len;
    logic                busy;
    logic                done;
    logic [DATA_W-1:0]   result;
    logic                overflow;
    // Input / weight RAM read port
    logic                rd_en;
    logic [ADDR_W-1:0]   x_addr;
    logic [ADDR_W-1:0]   w_addr;
    logic [DATA_W-1:0]   x_data;
    logic [DATA_W-1:0]   w_data;
    // External pipelined multiplier
    logic                mult_ce;
    logic                mult_sclr;
    logic [DATA_W-1:0]   mult_a;
    logic [DATA_W-1:0]   mult_b;
    logic [2*DATA_W-1:0] mult_p;

    modport slave (
        input  start, len, x_data, w_data, mult_p,
        output busy, done, result, overflow, rd_en, x_addr, w_addr,
               mult_ce, mult_sclr, mult_a, mult_b
    );

    modport master (
        output start, len, x_data, w_data, mult_p,
        input  busy, done, result, overflow, rd_en, x_addr, w_addr,
               mult_ce, mult_sclr, mult_a, mult_b
    );

endinterface

// File: rtl/neuron_mac_ctrl_fxp_saturate.sv
// fxp_saturate: rescales a wide signed accumulator from Q(2*FRAC_W) back to
// Q(FRAC_W) with an arithmetic shift (rounds toward -inf) and clamps it to
// the signed DATA_W range. Purely combinational; shared with activation blocks.
module fxp_saturate
    import nn_fxp_pkg::*;
#(
    parameter int ACC_W  = Q_ACC_W,
    parameter int DATA_W = Q_DATA_W,
    parameter int FRAC_W = Q_FRAC_W
) (
    input  logic signed [ACC_W-1:0] acc,
    output logic        [DATA_W-1:0] result,
    output logic                     overflow
);

    logic signed [ACC_W-1:0]  shifted;
    logic        [ACC_W-DATA_W:0] hi_bits;

    // Shift, then clamp when the bits above the result sign are not a pure sign extension.
    always_comb begin
        shifted  = acc >>> FRAC_W;
        hi_bits  = shifted[ACC_W-1:DATA_W-1];
        overflow = !((&hi_bits) || (~|hi_bits));
        if (!overflow)
            result = shifted[DATA_W-1:0];
        else if (shifted[ACC_W-1])
            result = {1'b1, {(DATA_W-1){1'b0}}};
        else
            result = {1'b0, {(DATA_W-1){1'b1}}};
    end

endmodule

// File: rtl/neuron_mac_ctrl.sv
// neuron_mac_ctrl: sequences an external pipelined signed multiplier to
// compute one neuron dot product sum(x[i]*w[i]) over len terms, fetching
// operands from the input/weight RAMs and returning a saturated Q result.
// A valid pipe of depth 1+MULT_LAT tracks each issued term from RAM read
// through the multiplier; its tail bit marks the product to accumulate.
module neuron_mac_ctrl
    import nn_fxp_pkg::*;
#(
    parameter int DATA_W   = Q_DATA_W,
    parameter int FRAC_W   = Q_FRAC_W,
    parameter int ACC_W    = Q_ACC_W,
    parameter int ADDR_W   = Q_ADDR_W,
    parameter int MULT_LAT = Q_MULT_LAT
) (
    input logic              clk,
    input logic              rst,
    neuron_mac_ctrl_if.slave bus
);

    logic [2:0]              state;
    logic [2:0]              state_nxt;
    logic [ADDR_W-1:0]       len_q;
    logic [ADDR_W-1:0]       addr;
    logic [MULT_LAT:0]       vpipe;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] acc_nxt;
    logic [DATA_W-1:0]       result_q;
    logic                    overflow_q;
    logic [DATA_W-1:0]       sat_result;
    logic                    sat_overflow;
    logic                    last_issue;
    logic                    tail;
    logic                    pipe_busy;

    assign last_issue = (addr == len_q - ADDR_W'(1));
    assign tail       = vpipe[MULT_LAT];
    // Terms still in the RAM-data stage or inside the multiplier need ce.
    assign pipe_busy  = |vpipe[MULT_LAT-1:0];

    // Accumulator input: add the sign-extended product when the tail term arrives.
    always_comb begin
        acc_nxt = acc;
        if (tail)
            acc_nxt = acc + $signed({{(ACC_W-2*DATA_W){bus.mult_p[2*DATA_W-1]}}, bus.mult_p});
    end

    // Saturated result of the accumulator including the product landing this cycle,
    // so it can be registered on the same edge that enters DONE.
    fxp_saturate #(
        .ACC_W  (ACC_W),
        .DATA_W (DATA_W),
        .FRAC_W (FRAC_W)
    ) u_sat (
        .acc      (acc_nxt),
        .result   (sat_result),
        .overflow (sat_overflow)
    );

    // Next-state decode for the IDLE/CLEAR/ISSUE/DRAIN/DONE sequence.
    always_comb begin
        // NOTE: default the output before the case so every path assigns it and no latch is inferred.
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = (bus.len == '0) ? DONE : CLEAR;
            CLEAR:   state_nxt = ISSUE;
            ISSUE:   if (last_issue) state_nxt = DRAIN;
            DRAIN:   if (tail && !pipe_busy) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register; reset aborts any operation without producing done.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential logic uses non-blocking assignments so all registers see pre-edge values.
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Operand address, valid pipe, accumulator and held result.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: every datapath register, accumulator and valid pipe included, is reset so an
        // aborted run leaves no stale term behind; there is no memory array in this block.
        if (rst) begin
            len_q      <= '0;
            addr       <= '0;
            vpipe      <= '0;
            acc        <= '0;
            result_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            vpipe <= {vpipe[MULT_LAT-1:0], (state == ISSUE)};

            if (state == IDLE && bus.start)
                len_q <= bus.len;

            if (state == CLEAR) begin
                acc  <= '0;
                addr <= '0;
            end else begin
                acc <= acc_nxt;
                if (state == ISSUE && !last_issue)
                    addr <= addr + ADDR_W'(1);
            end

            if (state_nxt == DONE) begin
                if (state == DRAIN) begin
                    result_q   <= sat_result;
                    overflow_q <= sat_overflow;
                end else begin
                    result_q   <= '0;
                    overflow_q <= 1'b0;
                end
            end
        end
    end

    assign bus.busy      = (state != IDLE);
    assign bus.done      = (state == DONE);
    assign bus.result    = result_q;
    assign bus.overflow  = overflow_q;
    assign bus.rd_en     = (state == ISSUE);
    assign bus.x_addr    = addr;
    assign bus.w_addr    = addr;
    // CLEAR also needs ce so the clear reaches every multiplier stage.
    assign bus.mult_ce   = pipe_busy || (state == CLEAR);
    assign bus.mult_sclr = (state == CLEAR);
    assign bus.mult_a    = bus.x_data;
    assign bus.mult_b    = bus.w_data;

endmodule
